// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity accumulator: FSM states, MODE
// encodings and the ceil(log2) used to size the word counter.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/parity_accum_if.sv
// Handshake bundle between a word producer / result consumer and parity_accum.
interface parity_accum_if
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 255
);
  localparam int CW = clog2(MAX_WORDS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_col;
  logic             out_par;
  logic [CW-1:0]    out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_col, out_par, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_col, out_par, out_cnt, out_ovf
  );
endinterface

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a word, built as a balanced tree of
// 2-input XORs by splitting the word in halves recursively.
module parity_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  output logic             par
);
  if (WIDTH == 1) begin : g_leaf
    assign par = word[0];
  end else begin : g_split
    localparam int LO = WIDTH / 2;
    logic par_lo;
    logic par_hi;

    parity_tree #(.WIDTH(LO)) u_lo (
      .word (word[LO-1:0]),
      .par  (par_lo)
    );

    parity_tree #(.WIDTH(WIDTH - LO)) u_hi (
      .word (word[WIDTH-1:LO]),
      .par  (par_hi)
    );

    assign par = par_lo ^ par_hi;
  end
endmodule

// File: rtl/parity_accum.sv
// Frame parity accumulator: XORs words of a frame into a column parity, total
// parity and saturating word count, and holds the result until consumed.
//
// state | meaning
// IDLE  | waiting for the first word of a frame
// ACC   | frame open, accumulating words
// HOLD  | result presented on out_*, input stalled until out_ready
module parity_accum
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  parity_accum_if.slave bus
);
  localparam int            CW      = clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] col_q, col_d;
  logic             par_q, par_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             word_par;
  logic             xfer;

  parity_tree #(.WIDTH(WIDTH)) u_tree (
    .word (bus.in_data),
    .par  (word_par)
  );

  assign bus.in_ready = rst_n && (state_q != HOLD);
  assign xfer         = bus.in_valid && bus.in_ready;

  // par_q carries the latched MODE folded in, so out_par needs no extra XOR
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          col_d = bus.in_data;
          par_d = word_par ^ (bus.mode == MODE_ODD);
          cnt_d = CW'(1);
          ovf_d = 1'b0;
          if (bus.in_last) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (xfer) begin
          col_d = col_q ^ bus.in_data;
          par_d = par_q ^ word_par;
          if (cnt_q < MAX_CNT) cnt_d = cnt_q + CW'(1);
          else                 ovf_d = 1'b1;
          if (bus.in_last) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      par_q       <= MODE_EVEN;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = col_q;
  assign bus.out_par   = par_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_parity_accum.sv
// Bench for parity_accum: directed frames plus random frames checked against
// a frame-level model, on two instances (MAX_WORDS 255 and 3) fed identically.
module tb_parity_accum;
  import parity_pkg::*;

  localparam int W     = 8;
  localparam int MAX_A = 255;
  localparam int MAX_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] frame_q[$];

  parity_accum_if #(.WIDTH(W), .MAX_WORDS(MAX_A)) ia ();
  parity_accum_if #(.WIDTH(W), .MAX_WORDS(MAX_B)) ib ();

  assign ib.in_valid  = ia.in_valid;
  assign ib.in_data   = ia.in_data;
  assign ib.in_last   = ia.in_last;
  assign ib.mode      = ia.mode;
  assign ib.out_ready = ia.out_ready;

  parity_accum #(.WIDTH(W), .MAX_WORDS(MAX_A)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  parity_accum #(.WIDTH(W), .MAX_WORDS(MAX_B)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  // Frame-level reference: result depends only on the set of words and the first MODE.
  function automatic logic [7:0] exp_col();
    logic [7:0] c;
    c = 8'h00;
    foreach (frame_q[i]) c = c ^ frame_q[i];
    return c;
  endfunction

  function automatic logic exp_par(input logic m);
    int ones;
    ones = 0;
    foreach (frame_q[i]) ones += $countones(frame_q[i]);
    return ((ones % 2) == 1) ^ m;
  endfunction

  function automatic int exp_cnt(input int max_words);
    return (frame_q.size() > max_words) ? max_words : frame_q.size();
  endfunction

  function automatic logic exp_ovf(input int max_words);
    return frame_q.size() > max_words;
  endfunction

  // Returns on the falling edge right after the last transfer edge.
  task automatic drive_frame(input logic m, input bit flip, input bit close,
                             input int gap_first, input int gap_max);
    int waited;
    bit took;
    ia.mode = m;
    for (int i = 0; i < frame_q.size(); i++) begin
      ia.in_valid = 1'b1;
      ia.in_data  = frame_q[i];
      ia.in_last  = close && (i == frame_q.size() - 1);
      took   = 1'b0;
      waited = 0;
      while (!took && waited < 50) begin
        took = ia.in_ready;
        @(posedge clk);
        @(negedge clk);
        waited++;
      end
      ia.in_valid = 1'b0;
      ia.in_last  = 1'b0;
      if (!took) begin
        n_cmp++;
        n_bad++;
        $display("FAIL handshake: in_ready=%b after %0d cycles, required 1", ia.in_ready, waited);
        return;
      end
      if (i == 0 && flip) ia.mode = ~m;
      if (i < frame_q.size() - 1) begin
        if (i == 0) repeat (gap_first) @(negedge clk);
        else        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
    end
  endtask

  task automatic release_result();
    ia.out_ready = 1'b1;
    @(negedge clk);
    ia.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ia.in_valid  = 1'b0;
    ia.in_data   = '0;
    ia.in_last   = 1'b0;
    ia.mode      = MODE_EVEN;
    ia.out_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ia.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, required 0", ia.in_ready);
    end
    n_cmp++;
    if ({ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b col=%h par=%b cnt=%0d ovf=%b, required all 0",
               ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ia.in_ready !== 1'b1 || ia.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1/0",
               ia.in_ready, ia.out_valid);
    end
  endtask

  task automatic test_single_word();
    frame_q = {};
    frame_q.push_back(8'hA5);
    drive_frame(MODE_EVEN, 1'b0, 1'b1, 0, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b1 || ia.out_col !== 8'hA5 || ia.out_par !== 1'b0 ||
        ia.out_cnt !== 8'd1 || ia.out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL single_word: got v=%b col=%h par=%b cnt=%0d ovf=%b, required 1 a5 0 1 0",
               ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf);
    end
    release_result();
  endtask

  task automatic test_bubble_frame();
    frame_q = {};
    frame_q.push_back(8'h0F);
    frame_q.push_back(8'hF0);
    frame_q.push_back(8'h01);
    drive_frame(MODE_ODD, 1'b0, 1'b1, 1, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b1 || ia.out_col !== 8'hFE || ia.out_par !== 1'b0 ||
        ia.out_cnt !== 8'd3 || ia.out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL bubble_frame: got v=%b col=%h par=%b cnt=%0d ovf=%b, required 1 fe 0 3 0",
               ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    frame_q = {};
    frame_q.push_back(8'h3C);
    frame_q.push_back(8'h5A);
    drive_frame(MODE_ODD, 1'b0, 1'b1, 0, 0);
    ia.in_valid = 1'b1;
    ia.in_data  = 8'hFF;
    ia.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1 || ia.out_col !== 8'h66 ||
          ia.out_par !== 1'b1 || ia.out_cnt !== 8'd2 || ia.out_ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b col=%h par=%b cnt=%0d ovf=%b, required 0 1 66 1 2 0",
                 c, ia.in_ready, ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf);
      end
    end
    ia.out_ready = 1'b1;
    @(negedge clk);
    ia.out_ready = 1'b0;
    ia.in_valid  = 1'b0;
    ia.in_last   = 1'b0;
    n_cmp++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: got v=%b rdy=%b, required 0 1", ia.out_valid, ia.in_ready);
    end
    frame_q = {};
    frame_q.push_back(8'h11);
    drive_frame(MODE_EVEN, 1'b0, 1'b1, 0, 0);
    n_cmp++;
    if (ia.out_col !== 8'h11 || ia.out_par !== 1'b0 || ia.out_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL backpressure_no_consume: got col=%h par=%b cnt=%0d, required 11 0 1",
               ia.out_col, ia.out_par, ia.out_cnt);
    end
    release_result();
  endtask

  task automatic test_saturation();
    frame_q = {};
    repeat (5) frame_q.push_back(8'h01);
    drive_frame(MODE_EVEN, 1'b0, 1'b1, 0, 0);
    n_cmp++;
    if (ib.out_valid !== 1'b1 || ib.out_col !== 8'h01 || ib.out_par !== 1'b1 ||
        ib.out_cnt !== 2'd3 || ib.out_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate_max3: got v=%b col=%h par=%b cnt=%0d ovf=%b, required 1 01 1 3 1",
               ib.out_valid, ib.out_col, ib.out_par, ib.out_cnt, ib.out_ovf);
    end
    n_cmp++;
    if (ia.out_cnt !== 8'd5 || ia.out_ovf !== 1'b0 || ia.out_par !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate_max255: got cnt=%0d ovf=%b par=%b, required 5 0 1",
               ia.out_cnt, ia.out_ovf, ia.out_par);
    end
    release_result();
  endtask

  task automatic test_reset_midframe();
    frame_q = {};
    frame_q.push_back(8'hC3);
    frame_q.push_back(8'h81);
    drive_frame(MODE_ODD, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf} !== '0 ||
        ia.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midframe: got v=%b col=%h par=%b cnt=%0d ovf=%b rdy=%b, required all 0",
               ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf, ia.in_ready);
    end
    ia.in_valid = 1'b1;
    ia.in_data  = 8'h77;
    ia.in_last  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ia.in_valid = 1'b0;
    ia.in_last  = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ia.out_valid !== 1'b0 || ia.out_cnt !== 8'd0 || ia.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_no_accept: got v=%b cnt=%0d rdy=%b, required 0 0 1",
               ia.out_valid, ia.out_cnt, ia.in_ready);
    end
    frame_q = {};
    frame_q.push_back(8'h03);
    drive_frame(MODE_EVEN, 1'b0, 1'b1, 0, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b1 || ia.out_col !== 8'h03 || ia.out_par !== 1'b0 ||
        ia.out_cnt !== 8'd1 || ia.out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_new_frame: got v=%b col=%h par=%b cnt=%0d ovf=%b, required 1 03 0 1 0",
               ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf);
    end
    release_result();
  endtask

  task automatic test_mode_latch();
    frame_q = {};
    frame_q.push_back(8'h80);
    frame_q.push_back(8'h00);
    drive_frame(MODE_EVEN, 1'b1, 1'b1, 0, 0);
    n_cmp++;
    if (ia.out_par !== 1'b1 || ia.out_col !== 8'h80 || ia.out_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL mode_latch: got par=%b col=%h cnt=%0d, required 1 80 2",
               ia.out_par, ia.out_col, ia.out_cnt);
    end
    release_result();
  endtask

  task automatic test_random();
    logic m;
    bit   flip;
    int   len;
    for (int f = 0; f < 25; f++) begin
      frame_q = {};
      len  = $urandom_range(6, 1);
      for (int k = 0; k < len; k++) frame_q.push_back(8'($urandom));
      m    = 1'($urandom);
      flip = 1'($urandom);
      drive_frame(m, flip, 1'b1, $urandom_range(2, 0), 2);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      n_cmp++;
      if (ia.out_valid !== 1'b1 || ia.out_col !== exp_col() || ia.out_par !== exp_par(m) ||
          ia.out_cnt !== 8'(exp_cnt(MAX_A)) || ia.out_ovf !== exp_ovf(MAX_A)) begin
        n_bad++;
        $display("FAIL random_a[%0d]: got v=%b col=%h par=%b cnt=%0d ovf=%b, required 1 %h %b %0d %b",
                 f, ia.out_valid, ia.out_col, ia.out_par, ia.out_cnt, ia.out_ovf,
                 exp_col(), exp_par(m), exp_cnt(MAX_A), exp_ovf(MAX_A));
      end
      n_cmp++;
      if (ib.out_valid !== 1'b1 || ib.out_col !== exp_col() || ib.out_par !== exp_par(m) ||
          ib.out_cnt !== 2'(exp_cnt(MAX_B)) || ib.out_ovf !== exp_ovf(MAX_B)) begin
        n_bad++;
        $display("FAIL random_b[%0d]: got v=%b col=%h par=%b cnt=%0d ovf=%b, required 1 %h %b %0d %b",
                 f, ib.out_valid, ib.out_col, ib.out_par, ib.out_cnt, ib.out_ovf,
                 exp_col(), exp_par(m), exp_cnt(MAX_B), exp_ovf(MAX_B));
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bubble_frame();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    test_mode_latch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
